// File: rtl/alu_defs.sv
// Shared ALU control codes and execute-unit FSM states.
// The ALU control decoder uses the same constants.
package alu_defs;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ID/EX operand latch and the execute ALU.
interface alu_exec_unit_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_ctl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, hi, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, hi, zero, illegal
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle over WIDTH cycles.
// hi/lo carry the value the product register takes at the next edge, so the final product is visible while done is high.
module alu_mul_iter
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic [WIDTH:0]     sum;

    // The multiplier lives in the low half and shifts out as the sum shifts in from the top.
    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
        prod_next = {sum, prod_q[WIDTH-1:1]};
    end

    assign done = busy_q && (count_q == CW'(WIDTH - 1));
    assign hi   = prod_next[2*WIDTH-1:WIDTH];
    assign lo   = prod_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= '0;
            mcand_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            prod_q  <= {{WIDTH{1'b0}}, b};
            mcand_q <= a;
            count_q <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q  <= prod_next;
            count_q <= count_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus an iterative unsigned MUL.
module alu_exec_unit
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_unit_if.slave   bus
);

    alu_state_t       state;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_q;
    logic             zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign bus.in_ready  = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.alu_ctl == ALU_MUL);

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.alu_ctl)
            ALU_AND: alu_res = bus.src_a & bus.src_b;
            ALU_OR:  alu_res = bus.src_a | bus.src_b;
            ALU_ADD: alu_res = bus.src_a + bus.src_b;
            ALU_SUB: alu_res = bus.src_a - bus.src_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_NOR: alu_res = ~(bus.src_a | bus.src_b);
            ALU_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (accept && is_mul),
        .a     (bus.src_a),
        .b     (bus.src_b),
        .done  (mul_done),
        .hi    (mul_hi),
        .lo    (mul_lo)
    );

    // In DONE a transfer and a new accept can share an edge; the accept assignments win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if ((state == ST_DONE) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                    if (accept) begin
                        if (is_mul) begin
                            out_valid_q <= 1'b0;
                            state       <= ST_MUL;
                        end else begin
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                            result_q    <= alu_res;
                            hi_q        <= '0;
                            zero_q      <= (alu_res == '0);
                            illegal_q   <= alu_ill;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                        result_q    <= mul_lo;
                        hi_q        <= mul_hi;
                        zero_q      <= (mul_lo == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
